// File: rtl/vid_comp_pkg.sv
// Shared types and constants for the view compositor.
package vid_comp_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    LAYOUT_SINGLE = 1'b0,
    LAYOUT_QUAD   = 1'b1
  } layout_e;

  localparam rgb444_t BOX_COLOR = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb444_t BLACK     = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/frame_sync.sv
// vsync rising-edge detector, frame counter and shadow-register load strobe.
module frame_sync #(
  parameter int unsigned FRAME_MOD = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vsync,
  output logic                         load_shadow,
  output logic                         frame_start,
  output logic [$clog2(FRAME_MOD)-1:0] frame_count
);

  localparam int unsigned FC_W = $clog2(FRAME_MOD);

  logic vsync_d;
  logic primed;
  logic edge_det;

  // primed masks the first sample after reset so a vsync already high is not taken as an edge
  assign edge_det    = primed & vsync & ~vsync_d;
  assign load_shadow = edge_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      primed      <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vsync_d     <= vsync;
      primed      <= 1'b1;
      frame_start <= edge_det;
      if (edge_det) begin
        if (frame_count == FC_W'(FRAME_MOD - 1))
          frame_count <= '0;
        else
          frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/view_compositor.sv
// Multi-view compositor: quad/single layout with optional box overlay, 2-cycle latency.
// Box overlay is built only when VIEW_COMPOSITOR_BOX_OVERLAY_EN is defined.
module view_compositor
  import vid_comp_pkg::*;
#(
  parameter int unsigned N_VIEWS   = 4,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned LINE_T    = 2,
  parameter int unsigned FRAME_MOD = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   x_pixel,
  input  logic [9:0]                   y_pixel,
  input  logic                         display_enable,
  input  logic                         vsync,
  input  logic                         quad_mode,
  input  logic [1:0]                   view_sel,
  input  logic [N_VIEWS-1:0][11:0]     view_pix,
  input  logic [9:0]                   box_x0,
  input  logic [9:0]                   box_y0,
  input  logic [9:0]                   box_x1,
  input  logic [9:0]                   box_y1,
  input  logic                         box_valid,
  output logic [$clog2(FRAME_MOD)-1:0] frame_count,
  output logic                         frame_start,
  output logic [3:0]                   red_port,
  output logic [3:0]                   green_port,
  output logic [3:0]                   blue_port
);

  localparam logic [9:0] H_HALF = 10'(H_RES / 2);
  localparam logic [9:0] V_HALF = 10'(V_RES / 2);

  logic            load_shadow;
  layout_e         layout_q;
  logic [1:0]      view_sel_q;
  logic [3:0][11:0] views;
  logic [1:0]      quad_idx;
  logic [1:0]      sel_idx;
  rgb444_t         sel_pix;
  logic            box_hit;

  logic            de1;
  logic            hit1;
  rgb444_t         pix1;
  rgb444_t         rgb_q;

  frame_sync #(.FRAME_MOD(FRAME_MOD)) u_frame_sync (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .load_shadow (load_shadow),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layout_q   <= LAYOUT_QUAD;
      view_sel_q <= '0;
    end else if (load_shadow) begin
      layout_q   <= quad_mode ? LAYOUT_QUAD : LAYOUT_SINGLE;
      view_sel_q <= view_sel;
    end
  end

  // Pad to four lanes so absent views read as black without out-of-range indexing
  always_comb begin
    views = '0;
    for (int unsigned i = 0; i < N_VIEWS; i++) views[i] = view_pix[i];
  end

  always_comb begin
    quad_idx = {y_pixel >= V_HALF, x_pixel >= H_HALF};
    sel_idx  = (layout_q == LAYOUT_QUAD) ? quad_idx : view_sel_q;
    sel_pix  = (32'(sel_idx) < N_VIEWS) ? rgb444_t'(views[sel_idx]) : BLACK;
  end

`ifdef VIEW_COMPOSITOR_BOX_OVERLAY_EN
  localparam logic [10:0] LT = 11'(LINE_T);

  logic [9:0]  bx0_q, by0_q, bx1_q, by1_q;
  logic        box_valid_q;
  logic [10:0] lx, ly, ex0, ex1, ey0, ey1;
  logic        in_box;
  logic        near_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx0_q       <= '0;
      by0_q       <= '0;
      bx1_q       <= '0;
      by1_q       <= '0;
      box_valid_q <= 1'b0;
    end else if (load_shadow) begin
      bx0_q       <= box_x0;
      by0_q       <= box_y0;
      bx1_q       <= box_x1;
      by1_q       <= box_y1;
      box_valid_q <= box_valid;
    end
  end

  // Box corners are in quadrant units; full-screen view scales them by 2
  always_comb begin
    if (layout_q == LAYOUT_QUAD) begin
      lx  = {1'b0, x_pixel - (quad_idx[0] ? H_HALF : 10'd0)};
      ly  = {1'b0, y_pixel - (quad_idx[1] ? V_HALF : 10'd0)};
      ex0 = {1'b0, bx0_q};
      ex1 = {1'b0, bx1_q};
      ey0 = {1'b0, by0_q};
      ey1 = {1'b0, by1_q};
    end else begin
      lx  = {1'b0, x_pixel};
      ly  = {1'b0, y_pixel};
      ex0 = {bx0_q, 1'b0};
      ex1 = {bx1_q, 1'b0};
      ey0 = {by0_q, 1'b0};
      ey1 = {by1_q, 1'b0};
    end
    in_box    = (lx >= ex0) && (lx <= ex1) && (ly >= ey0) && (ly <= ey1);
    near_edge = ((lx - ex0) < LT) || ((ex1 - lx) < LT) ||
                ((ly - ey0) < LT) || ((ey1 - ly) < LT);
    box_hit   = box_valid_q && (bx0_q <= bx1_q) && (by0_q <= by1_q) &&
                in_box && near_edge &&
                ((layout_q == LAYOUT_SINGLE) || (quad_idx == 2'd0));
  end
`else
  logic unused_box;
  assign unused_box = ^{box_x0, box_y0, box_x1, box_y1, box_valid, 11'(LINE_T)};
  assign box_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de1   <= 1'b0;
      hit1  <= 1'b0;
      pix1  <= BLACK;
      rgb_q <= BLACK;
    end else begin
      de1  <= display_enable;
      hit1 <= box_hit;
      pix1 <= sel_pix;
      if (!de1)
        rgb_q <= BLACK;
      else if (hit1)
        rgb_q <= BOX_COLOR;
      else
        rgb_q <= pix1;
    end
  end

  assign red_port   = rgb_q.r;
  assign green_port = rgb_q.g;
  assign blue_port  = rgb_q.b;

endmodule

// File: tb/tb_view_compositor.sv
// Self-checking bench for view_compositor against a coordinate-rule reference model.
module tb_view_compositor;

  localparam int N_VIEWS   = 4;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int LINE_T    = 2;
  localparam int FRAME_MOD = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [9:0]       x_pixel, y_pixel;
  logic             display_enable;
  logic             vsync;
  logic             quad_mode;
  logic [1:0]       view_sel;
  logic [3:0][11:0] view_pix;
  logic [9:0]       box_x0, box_y0, box_x1, box_y1;
  logic             box_valid;
  logic [1:0]       frame_count;
  logic             frame_start;
  logic [3:0]       red_port, green_port, blue_port;
  logic [11:0]      rgb;

  assign rgb = {red_port, green_port, blue_port};

  always #5 clk = ~clk;

  view_compositor #(
    .N_VIEWS(N_VIEWS), .H_RES(H_RES), .V_RES(V_RES),
    .LINE_T(LINE_T), .FRAME_MOD(FRAME_MOD)
  ) dut (
    .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .display_enable(display_enable), .vsync(vsync), .quad_mode(quad_mode),
    .view_sel(view_sel), .view_pix(view_pix),
    .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
    .box_valid(box_valid), .frame_count(frame_count), .frame_start(frame_start),
    .red_port(red_port), .green_port(green_port), .blue_port(blue_port)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model of the per-frame configuration and frame counter
  bit m_quad;
  int m_sel, m_bx0, m_by0, m_bx1, m_by1, m_fc;
  bit m_bvalid;

  function automatic logic [11:0] model_pix(input int x, input int y, input bit de);
    int v, lx, ly, s, hx, hy, x0, x1, y0, y1;
    bit hit;
    if (!de) return 12'h000;
    if (m_quad) begin
      hx = (x >= H_RES / 2) ? 1 : 0;
      hy = (y >= V_RES / 2) ? 1 : 0;
      v  = 2 * hy + hx;
      lx = x - hx * (H_RES / 2);
      ly = y - hy * (V_RES / 2);
      s  = 1;
    end else begin
      v  = m_sel;
      lx = x;
      ly = y;
      s  = 2;
    end
    hit = 1'b0;
    x0 = m_bx0 * s; x1 = m_bx1 * s; y0 = m_by0 * s; y1 = m_by1 * s;
`ifdef VIEW_COMPOSITOR_BOX_OVERLAY_EN
    if (m_bvalid && m_bx0 <= m_bx1 && m_by0 <= m_by1 && (!m_quad || v == 0))
      if (lx >= x0 && lx <= x1 && ly >= y0 && ly <= y1 &&
          (lx - x0 < LINE_T || x1 - lx < LINE_T || ly - y0 < LINE_T || y1 - ly < LINE_T))
        hit = 1'b1;
`endif
    if (hit) return 12'h0F0;
    if (v >= N_VIEWS) return 12'h000;
    return view_pix[v];
  endfunction

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(posedge clk); #1;
    m_fc     = (m_fc + 1) % FRAME_MOD;
    m_quad   = quad_mode;
    m_sel    = view_sel;
    m_bx0    = box_x0; m_by0 = box_y0; m_bx1 = box_x1; m_by1 = box_y1;
    m_bvalid = box_valid;
    vsync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_quad = 1'b1; m_sel = 0; m_bvalid = 1'b0; m_fc = 0;
    m_bx0 = 0; m_by0 = 0; m_bx1 = 0; m_by1 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; display_enable = 1'b1;
    x_pixel = 10'd400; y_pixel = 10'd100;
    quad_mode = 1'b1; view_sel = 2'd0; box_valid = 1'b0;
    box_x0 = '0; box_y0 = '0; box_x1 = '0; box_y1 = '0;
    view_pix[0] = 12'h111; view_pix[1] = 12'h222; view_pix[2] = 12'h333; view_pix[3] = 12'h444;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h expected %h", rgb, 12'h000);
    else pass_cnt++;
    total_cnt++;
    if (frame_count !== 2'd0) $display("FAIL reset_fc: got %0d expected 0", frame_count);
    else pass_cnt++;
    total_cnt++;
    if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b expected 0", frame_start);
    else pass_cnt++;
    reset = 1'b0;
    // vsync already high at release must not count as a frame start
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (frame_start !== 1'b0 || frame_count !== 2'd0)
        $display("FAIL prime_ignore: got fs=%b fc=%0d expected fs=0 fc=0", frame_start, frame_count);
      else pass_cnt++;
    end
    vsync = 1'b0;
    display_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_frame_count();
    int fc_seq [7] = '{1, 2, 0, 1, 2, 0, 1};
    for (int k = 0; k < 7; k++) begin
      vsync = 1'b1;
      @(posedge clk); #1;
      m_fc = (m_fc + 1) % FRAME_MOD;
      total_cnt++;
      if (frame_start !== 1'b1 || frame_count !== 2'(fc_seq[k]))
        $display("FAIL frame_edge%0d: got fs=%b fc=%0d expected fs=1 fc=%0d",
                 k, frame_start, frame_count, fc_seq[k]);
      else pass_cnt++;
      vsync = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (frame_start !== 1'b0 || frame_count !== 2'(fc_seq[k]))
        $display("FAIL frame_after%0d: got fs=%b fc=%0d expected fs=0 fc=%0d",
                 k, frame_start, frame_count, fc_seq[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_quad_select();
    int px [6] = '{400, 100, 100, 400, 319, 320};
    int py [6] = '{100, 100, 300, 300, 239, 240};
    logic [11:0] lit [6] = '{12'h222, 12'h111, 12'h333, 12'h444, 12'h111, 12'h444};
    for (int k = 0; k < 6; k++) begin
      display_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      x_pixel = 10'(px[k]); y_pixel = 10'(py[k]); display_enable = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (rgb !== 12'h000) $display("FAIL quad_lat1_%0d: got %h expected %h", k, rgb, 12'h000);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (rgb !== lit[k] || rgb !== model_pix(px[k], py[k], 1'b1))
        $display("FAIL quad_sel_%0d: got %h expected %h", k, rgb, lit[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_frame_switch();
    quad_mode = 1'b0; view_sel = 2'd3;
    x_pixel = 10'd100; y_pixel = 10'd100; display_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h111) $display("FAIL midframe_hold: got %h expected %h", rgb, 12'h111);
    else pass_cnt++;
    pulse_vsync();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h444 || rgb !== model_pix(100, 100, 1'b1))
      $display("FAIL midframe_switch: got %h expected %h", rgb, 12'h444);
    else pass_cnt++;
    quad_mode = 1'b1; view_sel = 2'd0;
    pulse_vsync();
  endtask

  task automatic test_box();
    int px [6] = '{11, 30, 49, 12, 51, 331};
    logic [11:0] lit [6];
`ifdef VIEW_COMPOSITOR_BOX_OVERLAY_EN
    lit = '{12'h0F0, 12'h111, 12'h0F0, 12'h111, 12'h111, 12'h222};
`else
    lit = '{12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 12'h222};
`endif
    box_x0 = 10'd10; box_y0 = 10'd10; box_x1 = 10'd50; box_y1 = 10'd50; box_valid = 1'b1;
    pulse_vsync();
    for (int k = 0; k < 6; k++) begin
      x_pixel = 10'(px[k]); y_pixel = 10'd30; display_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (rgb !== lit[k] || rgb !== model_pix(px[k], 30, 1'b1))
        $display("FAIL box_%0d: got %h expected %h", k, rgb, lit[k]);
      else pass_cnt++;
    end
    box_x0 = 10'd50; box_x1 = 10'd10;
    pulse_vsync();
    x_pixel = 10'd11; y_pixel = 10'd30;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h111) $display("FAIL box_swapped: got %h expected %h", rgb, 12'h111);
    else pass_cnt++;
  endtask

  task automatic test_random_stream(input bit quad, input int sel, input int bx0, input int by0,
                                    input int bx1, input int by1, input int n);
    logic [11:0] exp_q [$];
    logic [11:0] expv;
    int x, y;
    bit de;
    quad_mode = quad; view_sel = 2'(sel);
    box_x0 = 10'(bx0); box_y0 = 10'(by0); box_x1 = 10'(bx1); box_y1 = 10'(by1); box_valid = 1'b1;
    pulse_vsync();
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        expv = exp_q.pop_front();
        total_cnt++;
        if (rgb !== expv) $display("FAIL stream_q%0b_%0d: got %h expected %h", quad, i - 2, rgb, expv);
        else pass_cnt++;
      end
      if (i < n) begin
        x  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 110)) : int'($urandom_range(0, H_RES - 1));
        y  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 110)) : int'($urandom_range(0, V_RES - 1));
        de = ($urandom_range(0, 7) != 0);
        x_pixel = 10'(x); y_pixel = 10'(y); display_enable = de;
        for (int v = 0; v < 4; v++) view_pix[v] = 12'($urandom_range(0, 4095));
        exp_q.push_back(model_pix(x, y, de));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_display_enable();
    view_pix[0] = 12'h111; view_pix[1] = 12'h222; view_pix[2] = 12'h333; view_pix[3] = 12'h444;
    x_pixel = 10'd400; y_pixel = 10'd100; display_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h000) $display("FAIL de_low: got %h expected %h", rgb, 12'h000);
    else pass_cnt++;
  endtask

  task automatic test_reset_midline();
    box_valid = 1'b0; quad_mode = 1'b0; view_sel = 2'd3;
    pulse_vsync();
    x_pixel = 10'd100; y_pixel = 10'd100; display_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h444) $display("FAIL pre_reset: got %h expected %h", rgb, 12'h444);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    model_reset();
    total_cnt++;
    if (rgb !== 12'h000 || frame_count !== 2'd0)
      $display("FAIL async_reset: got rgb=%h fc=%0d expected rgb=000 fc=0", rgb, frame_count);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rgb !== 12'h111 || rgb !== model_pix(100, 100, 1'b1))
      $display("FAIL restart_quad: got %h expected %h", rgb, 12'h111);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_count();
    test_quad_select();
    test_mid_frame_switch();
    test_box();
    test_random_stream(1'b1, 0, 10, 10, 50, 50, 200);
    test_random_stream(1'b0, int'($urandom_range(0, 3)), 20, 15, 40, 30, 200);
    test_display_enable();
    test_reset_midline();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/view_compositor.md
VIEW_COMPOSITOR -- requirements
Module: view_compositor

Interface
REQ-001 SHALL have parameter N_VIEWS, default 4, number of input views (2..4).
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-004 SHALL have parameter LINE_T, default 2, box border thickness in pixels.
REQ-005 SHALL have parameter FRAME_MOD, default 3, frame_count modulus.
REQ-006 clk  input  1  single system/pixel clock; all logic on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 x_pixel  input  10  current pixel column.
REQ-009 y_pixel  input  10  current pixel row.
REQ-010 display_enable  input  1  active-video qualifier.
REQ-011 vsync  input  1  frame sync level; rising edge marks frame start.
REQ-012 quad_mode  input  1  requested layout: 1 = 2x2 quadrants, 0 = single full-screen view.
REQ-013 view_sel  input  2  requested full-screen view index.
REQ-014 view_pix  input  N_VIEWS x 12  per-view RGB444 pixel {R,G,B}, valid with x/y.
REQ-015 box_x0, box_y0, box_x1, box_y1  input  10 each  box corners in quadrant coordinates, inclusive.
REQ-016 box_valid  input  1  box coordinates meaningful.
REQ-017 frame_count  output  $clog2(FRAME_MOD)  frame index modulo FRAME_MOD.
REQ-018 frame_start  output  1  one-cycle pulse on vsync rising edge.
REQ-019 red_port, green_port, blue_port  output  4 each  composited pixel.

Function
REQ-020 frame_start SHALL assert the cycle after vsync is sampled high having been low the previous cycle.
REQ-021 On frame_start, frame_count SHALL increment, wrapping FRAME_MOD-1 -> 0.
REQ-022 quad_mode, view_sel, box coords and box_valid SHALL be captured into shadow registers only on frame_start; mid-frame changes have no visible effect.
REQ-023 Quad layout: view index = {y_pixel >= V_RES/2, x_pixel >= H_RES/2}; index >= N_VIEWS SHALL output black.
REQ-024 Single layout: shadow view_sel selects the view; view_sel >= N_VIEWS SHALL output black.
REQ-025 Box hit SHALL be true when local (x,y) lies inside [x0..x1]x[y0..y1] and within LINE_T pixels of any edge; quad mode uses quadrant-local coordinates on view 0 only, single mode compares against coordinates shifted left by 1.
REQ-026 Box hit pixels SHALL output R=0, G=F, B=0; otherwise the selected view pixel.
REQ-027 box_x0 > box_x1 or box_y0 > box_y1 SHALL suppress the box for that frame.
REQ-028 Output SHALL lag x_pixel/y_pixel/display_enable/view_pix by exactly 2 cycles (stage 1: select + hit compare; stage 2: colour register).
REQ-029 When the delayed display_enable is 0, outputs SHALL be 0.
REQ-030 vsync rising within one cycle of reset deassertion SHALL be ignored (edge detector primed from reset value 0).

Reset
REQ-031 On reset: all RGB outputs 0, frame_count 0, frame_start 0, shadow quad_mode 1, view_sel 0, box_valid 0, pipeline valid bits 0.
REQ-032 Reset mid-frame SHALL blank output within 0 cycles (asynchronous) and restart in quad layout.

Configuration
REQ-033 Macro VIEW_COMPOSITOR_BOX_OVERLAY_EN: defined -> REQ-025..027 active; undefined -> no box logic, box ports present but ignored, latency unchanged at 2.

Structure
REQ-034 Package vid_comp_pkg SHALL hold rgb444_t, layout_e (LAYOUT_SINGLE, LAYOUT_QUAD), BOX_COLOR constant.
REQ-035 Sub-module frame_sync SHALL contain vsync edge detect, frame counter and shadow-register load strobe.

Verification
REQ-036 vsync toggled 7 times low->high -> frame_count sequence 1,2,0,1,2,0,1, one frame_start per edge.
REQ-037 quad_mode=1, views 0..3 = 0x111/0x222/0x333/0x444, x=400,y=100 -> output 0x222 two cycles later.
REQ-038 quad_mode changed 1->0 mid-frame with view_sel=3 -> quad output until next frame_start, then 0x444 full-screen.
REQ-039 box (10,10)-(50,50), LINE_T=2, quad, x=11,y=30 -> 0x0F0; x=30,y=30 -> view 0 pixel; swapped corners -> no box.
REQ-040 reset asserted mid-line -> RGB 0 immediately, frame_count 0; display_enable low -> RGB 0 after 2 cycles.
